// File: rtl/hamming_pkg.sv
// Shared (7,4) Hamming definitions for the serial encoder and decoder.
// Codeword positions 1..7 are held as cw[6:0], with cw[6] holding position 1.
package hamming_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int SYN_W  = 3;

  // Vector index of each 1-based codeword position
  localparam int POS1 = 6;
  localparam int POS2 = 5;
  localparam int POS3 = 4;
  localparam int POS4 = 3;
  localparam int POS5 = 2;
  localparam int POS6 = 1;
  localparam int POS7 = 0;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  // Returns {s3,s2,s1}; a nonzero value is the 1-based position in error
  function automatic logic [SYN_W-1:0] hamming_syndrome(input logic [CW_W-1:0] cw);
    logic s1, s2, s3;
    s1 = cw[POS1] ^ cw[POS3] ^ cw[POS5] ^ cw[POS7];
    s2 = cw[POS2] ^ cw[POS3] ^ cw[POS6] ^ cw[POS7];
    s3 = cw[POS4] ^ cw[POS5] ^ cw[POS6] ^ cw[POS7];
    return {s3, s2, s1};
  endfunction

  function automatic logic [CW_W-1:0] hamming_correct(input logic [CW_W-1:0] cw,
                                                      input logic [SYN_W-1:0] syn);
    logic [CW_W-1:0] fixed;
    fixed = cw;
    if (syn != '0) fixed[3'd7 - syn] = ~fixed[3'd7 - syn];
    return fixed;
  endfunction

  function automatic logic [DATA_W-1:0] hamming_data(input logic [CW_W-1:0] cw);
    return {cw[POS3], cw[POS5], cw[POS6], cw[POS7]};
  endfunction

endpackage

// File: rtl/hamming_serializer.sv
// One-entry holding buffer feeding a 4-bit valid/ready serializer, with sticky overrun.
// Handshake: a bit transfers on a cycle where s_out_valid && s_out_ready; s_out is held while stalled.
module hamming_serializer
  import hamming_pkg::*;
#(
  parameter bit OUT_MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              s_out,
  output logic              s_out_valid,
  input  logic              s_out_ready,
  output logic              overrun
);

  ser_state_t        state, state_next;
  logic [1:0]        idx, idx_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic              drain;

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    shreg_next  = shreg;
    drain       = 1'b0;
    s_out_valid = 1'b0;
    s_out       = 1'b0;
    case (state)
      SER_IDLE: begin
        if (hold_full) begin
          drain      = 1'b1;
          shreg_next = hold_data;
          idx_next   = 2'd0;
          state_next = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        s_out_valid = 1'b1;
        s_out       = OUT_MSB_FIRST ? shreg[2'd3 - idx] : shreg[idx];
        if (s_out_ready) begin
          if (idx == 2'd3) begin
            idx_next = 2'd0;
            // Reload straight from the buffer so consecutive nibbles leave without a bubble
            if (hold_full) begin
              drain      = 1'b1;
              shreg_next = hold_data;
            end else begin
              state_next = SER_IDLE;
            end
          end else begin
            idx_next = idx + 2'd1;
          end
        end
      end
      default: state_next = SER_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SER_IDLE;
      idx       <= 2'd0;
      shreg     <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      // A write that coincides with a drain is accepted; otherwise a full buffer drops it
      if (wr_valid && hold_full && !drain) begin
        overrun <= 1'b1;
      end else if (wr_valid) begin
        hold_full <= 1'b1;
        hold_data <= wr_data;
      end else if (drain) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hamming_decoder.sv
// Serial (7,4) Hamming decoder: deserialize, correct single-bit errors, re-serialize data.
// Optional corrected-error counter port err_count is enabled by defining HAMMING_DEC_ERR_CNT_EN.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter bit IN_MSB_FIRST  = 1'b1,
  parameter bit OUT_MSB_FIRST = 1'b1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_in,
  input  logic              s_in_valid,
  input  logic              frame_sync,
  output logic              s_out,
  output logic              s_out_valid,
  input  logic              s_out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic [SYN_W-1:0]  syndrome,
  output logic              err_corrected,
  output logic              overrun
`ifdef HAMMING_DEC_ERR_CNT_EN
  ,
  output logic [ERR_CNT_WIDTH-1:0] err_count
`endif
);

  logic [2:0]       bit_cnt, eff_cnt, wr_idx;
  logic [CW_W-1:0]  cw_reg, cw_next, cw_fixed;
  logic [SYN_W-1:0] syn_next;
  logic             word_done;

  // cw_next is the word including the bit arriving now, so the 7th bit decodes immediately
  always_comb begin
    eff_cnt          = frame_sync ? 3'd0 : bit_cnt;
    wr_idx           = IN_MSB_FIRST ? (3'd6 - eff_cnt) : eff_cnt;
    cw_next          = cw_reg;
    cw_next[wr_idx]  = s_in;
    word_done        = s_in_valid && (eff_cnt == 3'd6);
    syn_next         = hamming_syndrome(cw_next);
    cw_fixed         = hamming_correct(cw_next, syn_next);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt       <= 3'd0;
      cw_reg        <= '0;
      data_valid    <= 1'b0;
      data_out      <= '0;
      syndrome      <= '0;
      err_corrected <= 1'b0;
    end else begin
      data_valid <= word_done;
      if (s_in_valid) begin
        cw_reg  <= cw_next;
        bit_cnt <= (eff_cnt == 3'd6) ? 3'd0 : eff_cnt + 3'd1;
      end else if (frame_sync) begin
        bit_cnt <= 3'd0;
      end
      if (word_done) begin
        data_out      <= hamming_data(cw_fixed);
        syndrome      <= syn_next;
        err_corrected <= (syn_next != '0);
      end
    end
  end

`ifdef HAMMING_DEC_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (word_done && (syn_next != '0) && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  logic [31:0] err_cnt_width_unused;
  assign err_cnt_width_unused = ERR_CNT_WIDTH;
`endif

  hamming_serializer #(
    .OUT_MSB_FIRST(OUT_MSB_FIRST)
  ) u_ser (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (data_valid),
    .wr_data    (data_out),
    .s_out      (s_out),
    .s_out_valid(s_out_valid),
    .s_out_ready(s_out_ready),
    .overrun    (overrun)
  );

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: scoreboard queues for decoded words and serial bits.
// Define HAMMING_DEC_ERR_CNT_EN to also exercise the saturating error counter.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_in = 1'b0;
  logic       s_in_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       s_out_ready = 1'b1;
  logic       s_out, s_out_valid, data_valid, err_corrected, overrun;
  logic [3:0] data_out;
  logic [2:0] syndrome;
`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [1:0] err_count;
`endif

  int   n_vec = 0;
  int   n_miss = 0;
  logic [7:0] exp_dec_q[$];
  logic       exp_bit_q[$];

  always #5 clk = ~clk;

  hamming_decoder #(
    .IN_MSB_FIRST (1'b1),
    .OUT_MSB_FIRST(1'b1),
    .ERR_CNT_WIDTH(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_in         (s_in),
    .s_in_valid   (s_in_valid),
    .frame_sync   (frame_sync),
    .s_out        (s_out),
    .s_out_valid  (s_out_valid),
    .s_out_ready  (s_out_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .syndrome     (syndrome),
    .err_corrected(err_corrected),
    .overrun      (overrun)
`ifdef HAMMING_DEC_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[3] ^ d[2] ^ d[0];
    p2 = d[3] ^ d[1] ^ d[0];
    p3 = d[2] ^ d[1] ^ d[0];
    return {p1, p2, d[3], p3, d[2], d[1], d[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_in_valid = 1'b0;
    frame_sync = 1'b0;
    repeat (n) tick();
  endtask

  // Drives one codeword position 1 first; records the decode and (optionally) its serial bits
  task automatic send_word(input logic [6:0] cw, input logic fs, input logic [3:0] d,
                           input logic [2:0] syn, input logic keep_bits);
    exp_dec_q.push_back({d, syn, (syn != 3'd0)});
    if (keep_bits) begin
      for (int i = 3; i >= 0; i--) exp_bit_q.push_back(d[i]);
    end
    for (int k = 0; k < 7; k++) begin
      s_in       = cw[6-k];
      s_in_valid = 1'b1;
      frame_sync = fs && (k == 0);
      tick();
    end
    frame_sync = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    s_in_valid = 1'b0;
    while ((exp_dec_q.size() != 0 || exp_bit_q.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    n_vec++;
    if (exp_dec_q.size() != 0 || exp_bit_q.size() != 0) begin
      n_miss++;
      $display("FAIL %s drain: %0d words / %0d bits still outstanding, required 0",
               name, exp_dec_q.size(), exp_bit_q.size());
    end
  endtask

  task automatic scoreboard_mon();
    logic [7:0] e;
    logic       b;
    int         bit_pos;
    bit_pos = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bit_pos = 0;
        continue;
      end
      if (data_valid) begin
        n_vec++;
        if (exp_dec_q.size() == 0) begin
          n_miss++;
          $display("FAIL decode: unexpected data_valid data=%b syn=%b", data_out, syndrome);
        end else begin
          e = exp_dec_q.pop_front();
          if ({data_out, syndrome, err_corrected} !== e) begin
            n_miss++;
            $display("FAIL decode: got data=%b syn=%b err=%b, required data=%b syn=%b err=%b",
                     data_out, syndrome, err_corrected, e[7:4], e[3:1], e[0]);
          end
        end
      end
      if (bit_pos != 0) begin
        n_vec++;
        if (s_out_valid !== 1'b1) begin
          n_miss++;
          $display("FAIL bubble: s_out_valid=%b at bit %0d of a nibble, required 1",
                   s_out_valid, bit_pos);
        end
      end
      if (s_out_valid && s_out_ready) begin
        n_vec++;
        if (exp_bit_q.size() == 0) begin
          n_miss++;
          $display("FAIL serial: unexpected bit %b", s_out);
        end else begin
          b = exp_bit_q.pop_front();
          if (s_out !== b) begin
            n_miss++;
            $display("FAIL serial: s_out=%b, required %b", s_out, b);
          end
        end
        bit_pos = (bit_pos + 1) % 4;
      end
    end
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b1;
    s_in_valid = 1'b0;
    frame_sync = 1'b0;
    tick();
    exp_dec_q.delete();
    exp_bit_q.delete();
    n_vec++;
    if ({s_out, s_out_valid, data_out, data_valid, syndrome, err_corrected, overrun} !== 11'd0) begin
      n_miss++;
      $display("FAIL %s: outputs {s_out,vld,data,dv,syn,err,ovr}=%b, required all 0", name,
               {s_out, s_out_valid, data_out, data_valid, syndrome, err_corrected, overrun});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset("reset_state");
  endtask

  task automatic test_clean();
    s_out_ready = 1'b1;
    send_word(7'b0110011, 1'b1, 4'b1011, 3'd0, 1'b1);
    n_vec++;
    if (data_valid !== 1'b1) begin
      n_miss++;
      $display("FAIL clean_latency: data_valid=%b after bit 7, required 1", data_valid);
    end
    idle(1);
    n_vec++;
    if (data_valid !== 1'b0 || data_out !== 4'b1011) begin
      n_miss++;
      $display("FAIL clean_strobe: dv=%b data=%b, required dv=0 data=1011", data_valid, data_out);
    end
    wait_drain("clean");
  endtask

  task automatic test_single_error();
    logic [6:0] cw;
    send_word(7'b0110111, 1'b0, 4'b1011, 3'd5, 1'b1);
    for (int p = 1; p <= 7; p++) begin
      cw = 7'h7f ^ (7'b1 << (7 - p));
      send_word(cw, 1'b0, 4'b1111, 3'(p), 1'b1);
    end
    wait_drain("single_error");
  endtask

  task automatic test_back_to_back();
    send_word(7'b0000000, 1'b1, 4'b0000, 3'd0, 1'b1);
    send_word(7'b1111111, 1'b0, 4'b1111, 3'd0, 1'b1);
    send_word(7'b0110011, 1'b0, 4'b1011, 3'd0, 1'b1);
    wait_drain("back_to_back");
    n_vec++;
    if (overrun !== 1'b0) begin
      n_miss++;
      $display("FAIL back_to_back_overrun: overrun=%b, required 0", overrun);
    end
  endtask

  task automatic test_backpressure();
    logic held;
    s_out_ready = 1'b0;
    send_word(encode(4'b1001), 1'b1, 4'b1001, 3'd0, 1'b1);
    send_word(encode(4'b1100), 1'b0, 4'b1100, 3'd0, 1'b1);
    send_word(encode(4'b0011), 1'b0, 4'b0011, 3'd0, 1'b0);
    idle(3);
    n_vec++;
    if (overrun !== 1'b1) begin
      n_miss++;
      $display("FAIL backpressure_overrun: overrun=%b, required 1", overrun);
    end
    held = s_out;
    n_vec++;
    if (s_out_valid !== 1'b1 || held !== 1'b1) begin
      n_miss++;
      $display("FAIL backpressure_hold: vld=%b s_out=%b, required vld=1 s_out=1", s_out_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (s_out !== held) begin
        n_miss++;
        $display("FAIL backpressure_stable: s_out=%b, required %b", s_out, held);
      end
    end
    s_out_ready = 1'b1;
    wait_drain("backpressure");
    apply_reset("overrun_clear");
  endtask

  task automatic test_framing();
    for (int i = 0; i < 3; i++) begin
      s_in = 1'($urandom_range(0, 1));
      s_in_valid = 1'b1;
      tick();
    end
    send_word(7'b0110011, 1'b1, 4'b1011, 3'd0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      s_in = 1'($urandom_range(0, 1));
      s_in_valid = 1'b1;
      tick();
    end
    s_in_valid = 1'b0;
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    send_word(encode(4'b0100), 1'b0, 4'b0100, 3'd0, 1'b1);
    wait_drain("framing");
  endtask

  task automatic test_reset_mid();
    s_out_ready = 1'b0;
    send_word(encode(4'b0110), 1'b1, 4'b0110, 3'd0, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      s_in = 1'b1;
      s_in_valid = 1'b1;
      tick();
    end
    apply_reset("reset_mid");
    s_out_ready = 1'b1;
    send_word(encode(4'b0111), 1'b0, 4'b0111, 3'd0, 1'b1);
    wait_drain("reset_mid_after");
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic [2:0] pos;
    logic [6:0] cw;
    for (int n = 0; n < 20; n++) begin
      d   = 4'($urandom_range(0, 15));
      pos = 3'($urandom_range(0, 7));
      cw  = encode(d);
      if (pos != 3'd0) cw = cw ^ (7'b1 << (3'd7 - pos));
      send_word(cw, (n == 0), d, pos, 1'b1);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    wait_drain("random");
  endtask

`ifdef HAMMING_DEC_ERR_CNT_EN
  task automatic test_err_count();
    apply_reset("err_count_reset");
    n_vec++;
    if (err_count !== 2'd0) begin
      n_miss++;
      $display("FAIL err_count_reset: err_count=%0d, required 0", err_count);
    end
    for (int p = 1; p <= 5; p++) begin
      send_word(encode(4'b1010) ^ (7'b1 << (7 - p)), (p == 1), 4'b1010, 3'(p), 1'b1);
    end
    wait_drain("err_count");
    n_vec++;
    if (err_count !== 2'd3) begin
      n_miss++;
      $display("FAIL err_count_sat: err_count=%0d, required 3", err_count);
    end
  endtask
`endif

  initial begin
    fork
      scoreboard_mon();
    join_none
    test_reset();
    test_clean();
    test_single_error();
    test_back_to_back();
    test_backpressure();
    test_framing();
    test_reset_mid();
    test_random();
`ifdef HAMMING_DEC_ERR_CNT_EN
    test_err_count();
`endif
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
